// File: rtl/entrada_numero.sv
// -----------------------------------------------------------------------------
// entrada_numero
//
// Keypad entry stage that sits directly behind the 4x4 matrix scanner.
// The scanner only reports a held key while its column is being driven, so a
// single keystroke shows up as bursts of the key code separated by 4'hF.
// This block rebuilds one clean press event per keystroke from those bursts.
// It accumulates decimal digits into a binary operand and commits the operand
// on the enter key.
//
// Key map: 0-9 digit, A enter, E clear, B/C/D ignored, F no key.
// Optional feature macro: KEY_BACKSPACE_EN. When it is defined, B deletes the
// last digit. When it is undefined, B only produces a key event and no divider
// is built.
//
// Parameters
//   PRESS_CYC    identical non-F samples needed to accept a press
//   RELEASE_CYC  consecutive F samples needed to declare the key released
//   MAX_DIGITS   digit capacity of the operand (1..4)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   boton        scanner key code, 4'hF = no key
//   key_valid    one-cycle pulse per accepted keystroke
//   key_code     code of the last accepted key, held between pulses
//   value        operand being typed (binary, 0..9999)
//   digit_count  number of digits currently in value
//   operand      last committed operand
//   value_ready  one-cycle pulse when operand updates
// -----------------------------------------------------------------------------
module entrada_numero #(
  parameter int PRESS_CYC   = 8,
  parameter int RELEASE_CYC = 256,
  parameter int MAX_DIGITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  boton,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [13:0] value,
  output logic [2:0]  digit_count,
  output logic [13:0] operand,
  output logic        value_ready
);

  localparam int PW = $clog2(PRESS_CYC + 1);
  localparam int RW = $clog2(RELEASE_CYC + 1);

  localparam logic [PW-1:0] PRESS_LAST   = PW'(PRESS_CYC - 1);
  localparam logic [RW-1:0] RELEASE_LAST = RW'(RELEASE_CYC - 1);
  localparam logic [2:0]    MAX_CNT      = 3'(MAX_DIGITS);

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
`ifdef KEY_BACKSPACE_EN
  localparam logic [3:0] KEY_BACK  = 4'hB;
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  logic [3:0]    boton_q;
  logic [1:0]    state;
  logic [3:0]    cand;
  logic [PW-1:0] match_cnt;
  logic [RW-1:0] silence_cnt;

  logic [13:0]   value_x10;
  logic [13:0]   value_push;

  // Single input register; every decision below looks only at boton_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      boton_q <= KEY_NONE;
    end else begin
      boton_q <= boton;
    end
  end

  // Press/release reconstruction.
  // CONFIRM demands an unbroken run of the same code. Any F or any other
  // code aborts the candidate, and that aborting sample is not reused as a
  // new candidate. HELD waits for a long silence, which bridges the gaps the
  // scanner leaves between column bursts. Codes seen while HELD only restart
  // the silence timer, so a second key or a quick re-press is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cand        <= KEY_NONE;
      match_cnt   <= '0;
      silence_cnt <= '0;
      key_valid   <= 1'b0;
      key_code    <= KEY_NONE;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (boton_q != KEY_NONE) begin
            cand <= boton_q;
            if (PRESS_CYC <= 1) begin
              state       <= ST_HELD;
              key_valid   <= 1'b1;
              key_code    <= boton_q;
              match_cnt   <= '0;
              silence_cnt <= '0;
            end else begin
              state     <= ST_CONFIRM;
              match_cnt <= PW'(1);
            end
          end
        end

        ST_CONFIRM: begin
          if (boton_q == cand) begin
            if (match_cnt == PRESS_LAST) begin
              state       <= ST_HELD;
              key_valid   <= 1'b1;
              key_code    <= cand;
              match_cnt   <= '0;
              silence_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            state     <= ST_IDLE;
            match_cnt <= '0;
          end
        end

        ST_HELD: begin
          if (boton_q != KEY_NONE) begin
            silence_cnt <= '0;
          end else if (silence_cnt == RELEASE_LAST) begin
            state       <= ST_IDLE;
            silence_cnt <= '0;
          end else begin
            silence_cnt <= silence_cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          match_cnt   <= '0;
          silence_cnt <= '0;
        end
      endcase
    end
  end

  // value*10 built from shifts. With at most four digits the result stays
  // below 10000, so 14 bits never overflow.
  assign value_x10  = (value << 3) + (value << 1);
  assign value_push = value_x10 + {10'd0, key_code};

  // Accumulator. It acts on the key_valid cycle, so its outputs move on the
  // edge that ends the pulse. A digit typed at capacity is dropped silently.
  // Enter with no digits is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      value       <= '0;
      digit_count <= '0;
      operand     <= '0;
      value_ready <= 1'b0;
    end else begin
      value_ready <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (digit_count < MAX_CNT) begin
            value       <= value_push;
            digit_count <= digit_count + 3'd1;
          end
        end else if (key_code == KEY_ENTER) begin
          if (digit_count != 3'd0) begin
            operand     <= value;
            value_ready <= 1'b1;
            value       <= '0;
            digit_count <= '0;
          end
        end else if (key_code == KEY_CLEAR) begin
          value       <= '0;
          digit_count <= '0;
        end
`ifdef KEY_BACKSPACE_EN
        else if (key_code == KEY_BACK) begin
          if (digit_count != 3'd0) begin
            value       <= value / 14'd10;
            digit_count <= digit_count - 3'd1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_entrada_numero.sv
// -----------------------------------------------------------------------------
// tb_entrada_numero
//
// Bench for entrada_numero. A simple scanner model produces column bursts for
// each keystroke. Every cycle the DUT outputs are compared against a
// behavioural model of the keypad rules. On top of that, the directed
// scenarios check the final values they must produce.
// -----------------------------------------------------------------------------
module tb_entrada_numero;

  localparam int PRESS_CYC   = 8;
  localparam int RELEASE_CYC = 256;
  localparam int MAX_DIGITS  = 4;
  localparam int SCAN_DIV    = 50;
  localparam int GAP         = RELEASE_CYC + 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  boton;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] value;
  logic [2:0]  digit_count;
  logic [13:0] operand;
  logic        value_ready;

  int vectors     = 0;
  int miscompares = 0;
  int kvSeen      = 0;
  int vrSeen      = 0;

  // Reference model state: what the outputs must be after the current edge.
  int mBq, mKv, mKc, mValue, mCount, mOperand, mVr;
  bit armed;
  int streakCode, streakLen, quietLen;

  entrada_numero #(
    .PRESS_CYC  (PRESS_CYC),
    .RELEASE_CYC(RELEASE_CYC),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .boton      (boton),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .value      (value),
    .digit_count(digit_count),
    .operand    (operand),
    .value_ready(value_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  // A keystroke is accepted only while armed, after PRESS_CYC identical
  // non-F samples in a row. It then stays disarmed until RELEASE_CYC
  // consecutive F samples. Key effects land one edge after the pulse.
  task automatic modelEdge(input bit r, input int b);
    int s, oldKv, oldKc;
    if (r) begin
      mBq = 15; mKv = 0; mKc = 15; mValue = 0; mCount = 0; mOperand = 0; mVr = 0;
      armed = 1'b1; streakCode = 15; streakLen = 0; quietLen = 0;
      return;
    end
    s     = mBq;
    oldKv = mKv;
    oldKc = mKc;
    mKv   = 0;
    mVr   = 0;

    if (armed) begin
      if (streakLen == 0) begin
        if (s != 15) begin
          streakCode = s;
          streakLen  = 1;
        end
      end else if (s == streakCode) begin
        streakLen++;
      end else begin
        streakLen = 0;
      end
      if (streakLen >= PRESS_CYC) begin
        mKv = 1; mKc = streakCode; armed = 1'b0; streakLen = 0; quietLen = 0;
      end
    end else begin
      if (s != 15) quietLen = 0;
      else quietLen++;
      if (quietLen == RELEASE_CYC) begin
        armed = 1'b1; quietLen = 0; streakLen = 0;
      end
    end

    if (oldKv == 1) begin
      if (oldKc <= 9) begin
        if (mCount < MAX_DIGITS) begin
          mValue = mValue * 10 + oldKc;
          mCount++;
        end
      end else if (oldKc == 10) begin
        if (mCount > 0) begin
          mOperand = mValue; mVr = 1; mValue = 0; mCount = 0;
        end
      end else if (oldKc == 14) begin
        mValue = 0; mCount = 0;
      end
`ifdef KEY_BACKSPACE_EN
      else if (oldKc == 11) begin
        if (mCount > 0) begin
          mValue = mValue / 10; mCount--;
        end
      end
`endif
    end
    mBq = b;
  endtask

  // One clock cycle: drive inputs, step the model on the edge, compare on the
  // falling edge.
  task automatic applyStimulus(input bit r, input logic [3:0] b);
    rst   = r;
    boton = b;
    @(posedge clk);
    modelEdge(r, int'(b));
    @(negedge clk);
    checkOutput("key_valid",   int'(key_valid),   mKv);
    checkOutput("key_code",    int'(key_code),    mKc);
    checkOutput("value",       int'(value),       mValue);
    checkOutput("digit_count", int'(digit_count), mCount);
    checkOutput("operand",     int'(operand),     mOperand);
    checkOutput("value_ready", int'(value_ready), mVr);
    if (key_valid === 1'b1) kvSeen++;
    if (value_ready === 1'b1) vrSeen++;
  endtask

  // Scanner model: the key is visible one column slot out of four, starting
  // at a random scan phase. noise gives the per-cycle chance (percent) of a
  // stray code from another key.
  task automatic pressKey(input logic [3:0] code, input int hold, input int gap, input int noise);
    int phase;
    logic [3:0] b;
    phase = int'($urandom_range(0, 4 * SCAN_DIV - 1));
    for (int i = 0; i < hold; i++) begin
      b = (((i + phase) / SCAN_DIV) % 4 == 0) ? code : 4'hF;
      if (noise > 0 && int'($urandom_range(0, 99)) < noise) b = 4'($urandom_range(0, 14));
      applyStimulus(1'b0, b);
    end
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 4'hF);
  endtask

  task automatic steady(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, code);
  endtask

  initial begin
    int kv0, vr0, lat;
    logic [3:0] seq [5];
    logic [3:0] rk;
    rst = 1'b1;
    boton = 4'hF;

    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'hF);
    checkOutput("rst_key_valid", int'(key_valid), 0);
    checkOutput("rst_key_code",  int'(key_code), 15);
    checkOutput("rst_value",     int'(value), 0);
    checkOutput("rst_count",     int'(digit_count), 0);
    checkOutput("rst_operand",   int'(operand), 0);
    applyStimulus(1'b0, 4'hF);

    kv0 = kvSeen;
    pressKey(4'h7, 1000, GAP, 0);
    checkOutput("k7_pulses", kvSeen - kv0, 1);
    checkOutput("k7_code",   int'(key_code), 7);
    checkOutput("k7_value",  int'(value), 7);
    checkOutput("k7_count",  int'(digit_count), 1);
    pressKey(4'hE, 300, GAP, 0);

    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    kv0 = kvSeen;
    foreach (seq[i]) pressKey(seq[i], 300, GAP, 0);
    checkOutput("cap_pulses", kvSeen - kv0, 5);
    checkOutput("cap_value",  int'(value), 1234);
    checkOutput("cap_count",  int'(digit_count), 4);
    pressKey(4'hE, 300, GAP, 0);

    vr0 = vrSeen;
    pressKey(4'h4, 300, GAP, 0);
    pressKey(4'h2, 300, GAP, 0);
    pressKey(4'hA, 300, GAP, 0);
    checkOutput("enter_ready",   vrSeen - vr0, 1);
    checkOutput("enter_operand", int'(operand), 42);
    checkOutput("enter_value",   int'(value), 0);
    checkOutput("enter_count",   int'(digit_count), 0);
    vr0 = vrSeen;
    pressKey(4'hA, 300, GAP, 0);
    checkOutput("lone_enter_ready", vrSeen - vr0, 0);

    kv0 = kvSeen;
    steady(4'h5, PRESS_CYC - 1);
    steady(4'hF, 20);
    checkOutput("glitch_short", kvSeen - kv0, 0);
    steady(4'h5, PRESS_CYC);
    steady(4'hF, GAP);
    checkOutput("glitch_exact", kvSeen - kv0, 1);
    pressKey(4'hE, 300, GAP, 0);

    pressKey(4'h9, 300, GAP, 0);
    pressKey(4'hE, 300, GAP, 0);
    checkOutput("clear_value",   int'(value), 0);
    checkOutput("clear_count",   int'(digit_count), 0);
    checkOutput("clear_operand", int'(operand), 42);

    pressKey(4'h1, 300, GAP, 0);
    pressKey(4'h2, 300, GAP, 0);
    pressKey(4'h3, 300, GAP, 0);
    pressKey(4'hB, 300, GAP, 0);
`ifdef KEY_BACKSPACE_EN
    checkOutput("bksp_value", int'(value), 12);
    checkOutput("bksp_count", int'(digit_count), 2);
`else
    checkOutput("bksp_value", int'(value), 123);
    checkOutput("bksp_count", int'(digit_count), 3);
`endif
    pressKey(4'hE, 300, GAP, 0);

    // Re-press one sample short of the release window is swallowed.
    kv0 = kvSeen;
    steady(4'h7, 20);
    steady(4'hF, RELEASE_CYC - 1);
    steady(4'h7, 20);
    steady(4'hF, RELEASE_CYC);
    steady(4'h7, 20);
    steady(4'hF, GAP);
    checkOutput("lockout_pulses", kvSeen - kv0, 2);
    checkOutput("lockout_value",  int'(value), 77);
    pressKey(4'hE, 300, GAP, 0);

    // Reset while HELD with value 56, then the held key is seen again.
    pressKey(4'h5, 300, GAP, 0);
    steady(4'h6, 40);
    checkOutput("pre_rst_value", int'(value), 56);
    applyStimulus(1'b1, 4'h6);
    checkOutput("mid_rst_key_valid", int'(key_valid), 0);
    checkOutput("mid_rst_key_code",  int'(key_code), 15);
    checkOutput("mid_rst_value",     int'(value), 0);
    checkOutput("mid_rst_count",     int'(digit_count), 0);
    checkOutput("mid_rst_operand",   int'(operand), 0);
    checkOutput("mid_rst_ready",     int'(value_ready), 0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 4'h6);
      if (lat < 0 && key_valid === 1'b1) lat = k;
    end
    checkOutput("rst_repress_latency", lat, PRESS_CYC + 1);
    steady(4'hF, GAP);
    checkOutput("rst_repress_value", int'(value), 6);

    // Random keystrokes with random hold, gap and stray codes.
    for (int n = 0; n < 30; n++) begin
      rk = 4'($urandom_range(0, 15));
      if (rk == 4'hF) rk = 4'hA;
      pressKey(rk, int'($urandom_range(60, 900)), int'($urandom_range(50, 400)),
               int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/entrada_numero.md
# entrada_numero

Keypad entry stage placed directly downstream of the 4x4 matrix scanner. It turns the scanner's 4-bit key code stream into one clean press event per physical keystroke. Digits are accumulated into a binary operand of up to `MAX_DIGITS` decimal digits, and the operand is committed on the enter key. The scanner reports `4'hF` whenever the currently driven column has no pressed key, so a held key shows up only in bursts; this block rebuilds press and release from those bursts.

## Interface
- `PRESS_CYC`, default 8: consecutive identical non-`F` samples required to accept a press. Must be < scanner `SCAN_DIV`.
- `RELEASE_CYC`, default 256: consecutive cycles with no non-`F` sample required to declare release. Must be > 4·`SCAN_DIV`.
- `MAX_DIGITS`, default 4: digit capacity, range 1..4.

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `boton` input 4: scanner key code. `4'hF` means no key.
- `key_valid` output 1: one-cycle pulse per accepted keystroke.
- `key_code` output 4: code of the last accepted key, held between pulses.
- `value` output 14: operand being typed, binary, 0..9999.
- `digit_count` output 3: digits currently in `value`.
- `operand` output 14: last committed operand.
- `value_ready` output 1: one-cycle pulse when `operand` updates.

## Operation
- Key map: `0`–`9` are digits. `A` is enter. `E` (`*`) is clear. `B`, `C` and `D` are ignored unless `KEY_BACKSPACE_EN` is defined. `F` is no key; `#` cannot be distinguished from no key and is never seen.
- `boton` is registered once into `boton_q`. All decisions use `boton_q`.
- FSM states:
  - IDLE → CONFIRM when `boton_q` ≠ F. Latch the candidate code and set the match count to 1.
  - CONFIRM: the count increments while `boton_q` equals the candidate.
    - `boton_q` = F or a different code → IDLE. No event.
    - Count reaches `PRESS_CYC` → HELD, pulse `key_valid`, update `key_code`.
  - HELD: the silence counter clears on any non-`F` sample, including a different code (a second key is ignored), and increments on `F`.
    - Silence counter reaches `RELEASE_CYC` → IDLE.
- Accumulator actions, applied on the `key_valid` cycle:
  - Digit `d` with `digit_count` < `MAX_DIGITS` → `value` ← `value`·10 + `d` and `digit_count`+1. At capacity the digit is dropped, but `key_valid` still pulses.
  - `A` with `digit_count` > 0 → `operand` ← `value`, `value_ready` pulses, `value` ← 0, `digit_count` ← 0.
  - `A` with `digit_count` = 0 → no effect and no `value_ready`.
  - `E` → `value` ← 0 and `digit_count` ← 0. `operand` is untouched.
- Arithmetic: unsigned, 14 bits. No overflow is possible because `MAX_DIGITS` ≤ 4.

## Timing
- Reset values: `key_valid` = 0, `key_code` = `4'hF`, `value` = 0, `digit_count` = 0, `operand` = 0, `value_ready` = 0. FSM in IDLE, all counters 0.
- Reset mid-operation discards any partial press. A key still held after `rst` falls is detected as a new press.
- Press latency: `key_valid` is high in cycle `PRESS_CYC`+1 counted from the first edge at which `boton` carries the stable code. The extra cycle is the input register.
- `value`, `digit_count`, `operand` and `value_ready` change on the edge that ends the `key_valid` cycle. They are therefore visible one cycle after `key_valid`.
- `value_ready` and the new `operand` appear in the same cycle.
- Release latency is `RELEASE_CYC` cycles after the last non-`F` sample. Before that, no new press can be accepted, including a quick re-press of the same key.
- At most one `key_valid` per IDLE→HELD transition.

## Configuration
- `KEY_BACKSPACE_EN` defined: key `B` deletes the last digit.
  - `value` ← `value`/10, `digit_count` − 1.
  - No effect at `digit_count` = 0.
- `KEY_BACKSPACE_EN` undefined: `B` only pulses `key_valid`/`key_code` and does not change the accumulator. No divider logic is synthesized.

## Test plan
- Scanner model, `SCAN_DIV` = 50, key `7` held for 1000 cycles then released.
  - → exactly one `key_valid` with `key_code` = 7.
  - → `value` = 7, `digit_count` = 1.
  - → FSM back in IDLE 256 cycles after the last `7` sample.
- Keys 1,2,3,4,5, each pressed and released.
  - → five `key_valid` pulses.
  - → `value` = 1234, `digit_count` = 4; the `5` is dropped.
- Keys 4,2,A.
  - → `operand` = 42 with a single `value_ready` pulse.
  - → `value` = 0, `digit_count` = 0.
  - A following lone `A` produces no `value_ready`.
- Glitch: `boton` = 5 for 7 cycles, then F.
  - → no `key_valid`, state returns to IDLE.
  - The same with 8 cycles → one `key_valid`.
- Keys 9,E → `value` = 0, `digit_count` = 0, `operand` unchanged.
  - With `KEY_BACKSPACE_EN`: 1,2,3,B → `value` = 12, `digit_count` = 2.
  - Without it: the same sequence → `value` = 123, `digit_count` = 3.
- `rst` asserted for one cycle while in HELD with `value` = 56.
  - → all outputs at reset values the next cycle.
  - → the still-held key is re-accepted `PRESS_CYC`+1 cycles after `boton` next shows its code.
